// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver:
// glyph table in {g,f,e,d,c,b,a} order and segment bit indices.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0111111,
        7'b0000110,
        7'b1011011,
        7'b1001111,
        7'b1100110,
        7'b1101101,
        7'b1111101,
        7'b0000111,
        7'b1111111,
        7'b1101111,
        7'b1110111,
        7'b1111100,
        7'b0111001,
        7'b1011110,
        7'b1111001,
        7'b1110001
    };

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// Hex nibble to active-high segment pattern.
// Combinational lookup into the shared glyph table.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner with a double-buffered
// display register that only updates on frame boundaries.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIV            = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYCLES);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pend_q, pend_d;
    logic                tick_q;
    logic [4*DIGITS-1:0] sh_data_q, act_data_q;
    logic [DIGITS-1:0]   sh_dp_q, act_dp_q;
    logic [DIGITS-1:0]   sh_blk_q, act_blk_q;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic       slot_end;
    logic       boundary;
    logic       apply;
    logic       lit;
    logic [3:0] nib;
    logic       dp_sel;
    logic       blk_sel;
    logic [6:0] seg_raw;

    assign slot_end = (cnt_q == CNT_LAST);
    assign boundary = slot_end && (idx_q == IDX_LAST);
    assign apply    = boundary && pend_q;

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // A load on the apply cycle keeps the update queued.
    always_comb begin
        pend_d = pend_q;
        if (load) begin
            pend_d = 1'b1;
        end else if (boundary) begin
            pend_d = 1'b0;
        end
    end

    always_comb begin
        nib     = '0;
        dp_sel  = 1'b0;
        blk_sel = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib     = act_data_q[4*k +: 4];
                dp_sel  = act_dp_q[k];
                blk_sel = act_blk_q[k];
            end
        end
    end

    seg7_decode u_decode (
        .nib_i (nib),
        .seg_o (seg_raw)
    );

    always_comb begin
        lit   = (cnt_q >= BLANK_C) && !blk_sel;
        seg_d = lit ? seg_raw : '0;
        dp_d  = lit && dp_sel;
        an_d  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            an_d[k] = lit && (idx_q == IDX_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            sh_blk_q   <= '1;
            act_data_q <= '0;
            act_dp_q   <= '0;
            act_blk_q  <= '1;
            seg_q      <= '0;
            dp_q       <= 1'b0;
            an_q       <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            tick_q <= boundary;
            if (load) begin
                sh_data_q <= data;
                sh_dp_q   <= dp;
                sh_blk_q  <= blank;
            end
            if (apply) begin
                act_data_q <= sh_data_q;
                act_dp_q   <= sh_dp_q;
                act_blk_q  <= sh_blk_q;
            end
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg_o      = seg_q ^ {7{SEG_INV}};
    assign dp_o       = dp_q ^ SEG_INV;
    assign an_o       = an_q ^ {DIGITS{AN_INV}};
    assign pending    = pend_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: scan order, double buffering, coincident load,
// blanking, async reset and inverted polarity.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;
    logic        pend_a, pend_b;
    logic        ft_a, ft_b;

    int checks;
    int errors;
    logic pend_exp;

    int          lda_j, ldb_j;
    logic [15:0] lda_d, ldb_d;
    logic [3:0]  lda_dp, ldb_dp, lda_bk, ldb_bk;

    seg7_scan_driver #(
        .DIGITS(4), .DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .data(data), .dp(dp), .blank(blank),
        .seg_o(seg_a), .dp_o(dp_a), .an_o(an_a),
        .pending(pend_a), .frame_tick(ft_a)
    );

    seg7_scan_driver #(
        .DIGITS(4), .DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) u_inv (
        .clk(clk), .rst_n(rst_n), .load(load),
        .data(data), .dp(dp), .blank(blank),
        .seg_o(seg_b), .dp_o(dp_b), .an_o(an_b),
        .pending(pend_b), .frame_tick(ft_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called on the sample where frame_tick is high; walks one frame.
    task automatic run_frame(input logic [27:0] segs,
                             input logic [3:0]  dpm,
                             input logic [3:0]  blk);
        logic       loaded;
        logic       lit;
        logic [3:0] e_an, i_an;
        logic [6:0] e_seg, i_seg;
        logic       e_dp;
        int         s, ph;
        loaded = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            tick();
            if (loaded) pend_exp = 1'b1;
            else if (j == 16) pend_exp = 1'b0;
            s     = (j - 1) / 4;
            ph    = (j - 1) % 4;
            lit   = (ph >= 1) && !blk[s];
            e_an  = '0;
            e_an[s] = lit;
            e_seg = lit ? segs[7*s +: 7] : 7'd0;
            e_dp  = lit && dpm[s];
            i_an  = ~e_an;
            i_seg = ~e_seg;
            chk("an", an_a, e_an);
            chk("seg", seg_a, e_seg);
            chk("dp", dp_a, e_dp);
            chk("pending", pend_a, pend_exp);
            chk("frame_tick", ft_a, j == 16);
            chk("an_inv", an_b, i_an);
            chk("seg_inv", seg_b, i_seg);
            chk("dp_inv", dp_b, !e_dp);
            load   = 1'b0;
            loaded = 1'b0;
            if (j == lda_j) begin
                load = 1'b1; data = lda_d; dp = lda_dp; blank = lda_bk;
                loaded = 1'b1;
            end
            if (j == ldb_j) begin
                load = 1'b1; data = ldb_d; dp = ldb_dp; blank = ldb_bk;
                loaded = 1'b1;
            end
        end
        lda_j = 0;
        ldb_j = 0;
    endtask

    initial begin
        int n;
        int ticks;
        checks = 0; errors = 0; pend_exp = 1'b0;
        lda_j = 0; ldb_j = 0;
        lda_d = '0; ldb_d = '0;
        lda_dp = '0; ldb_dp = '0; lda_bk = '0; ldb_bk = '0;
        rst_n = 1'b0; load = 1'b0;
        data = '0; dp = '0; blank = '0;

        repeat (3) tick();
        chk("rst_seg", seg_a, 7'h00);
        chk("rst_an", an_a, 4'h0);
        chk("rst_dp", dp_a, 1'b0);
        chk("rst_pend", pend_a, 1'b0);
        chk("rst_tick", ft_a, 1'b0);
        chk("rst_seg_inv", seg_b, 7'h7f);
        chk("rst_an_inv", an_b, 4'hf);
        chk("rst_dp_inv", dp_b, 1'b1);

        rst_n = 1'b1;
        n = 0;
        while (n < 40 && !ft_a) begin
            tick();
            chk("dark_an", an_a, 4'h0);
            n++;
        end
        chk("sync_tick", ft_a, 1'b1);
        chk("sync_cycles", n, 16);

        lda_j = 3; lda_d = 16'h1234; lda_dp = 4'b0001; lda_bk = 4'b0000;
        run_frame(28'h0, 4'h0, 4'hf);

        lda_j = 5; lda_d = 16'hffff; lda_dp = 4'h0; lda_bk = 4'h0;
        run_frame({7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110},
                  4'b0001, 4'b0000);

        lda_j = 3; lda_d = 16'haaaa; lda_dp = 4'h0; lda_bk = 4'h0;
        ldb_j = 9; ldb_d = 16'h0000; ldb_dp = 4'h0; ldb_bk = 4'h0;
        run_frame({4{7'b1110001}}, 4'h0, 4'h0);

        lda_j = 8;  lda_d = 16'h8888; lda_dp = 4'h0; lda_bk = 4'h0;
        ldb_j = 15; ldb_d = 16'h5678; ldb_dp = 4'h0; ldb_bk = 4'b0100;
        run_frame({4{7'b0111111}}, 4'h0, 4'h0);

        run_frame({4{7'b1111111}}, 4'h0, 4'h0);

        run_frame({7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111},
                  4'h0, 4'b0100);

        tick();
        tick();
        load = 1'b1; data = 16'h9999; dp = 4'h0; blank = 4'h0;
        tick();
        load = 1'b0;
        chk("mid_pend", pend_a, 1'b1);
        chk("mid_an", an_a, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_seg", seg_a, 7'h00);
        chk("async_an", an_a, 4'h0);
        chk("async_dp", dp_a, 1'b0);
        chk("async_pend", pend_a, 1'b0);
        chk("async_tick", ft_a, 1'b0);
        chk("async_seg_inv", seg_b, 7'h7f);
        chk("async_an_inv", an_b, 4'hf);
        @(negedge clk);
        rst_n = 1'b1;
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("post_rst_an", an_a, 4'h0);
            chk("post_rst_pend", pend_a, 1'b0);
            if (ft_a) ticks++;
        end
        chk("post_rst_ticks", ticks, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
